// File: rtl/store_commit_if.sv
// Upstream instruction, bus request and bus response signals of store_commit.
// The master modport is the committing block; slave is the core/bus side.
interface store_commit_if #(
  parameter int ADDR_W = 64
);
  logic              opcodeValidIn;
  logic              canStoreIn;
  logic              isMemoryAccessDestIn;
  logic [ADDR_W-1:0] memoryAddressDestIn;
  logic [ADDR_W-1:0] storeDataIn;
  logic [7:0]        opcodeIn;
  logic              reqcycOut;
  logic [ADDR_W-1:0] reqOut;
  logic [12:0]       reqtagOut;
  logic              reqackIn;
  logic              respcycIn;
  logic              respackOut;
  logic              stallOut;
  logic              storeDoneOut;
  logic              timeoutErrOut;

  modport master (
    input  opcodeValidIn, canStoreIn, isMemoryAccessDestIn, memoryAddressDestIn,
           storeDataIn, opcodeIn, reqackIn, respcycIn,
    output reqcycOut, reqOut, reqtagOut, respackOut, stallOut, storeDoneOut,
           timeoutErrOut
  );

  modport slave (
    output opcodeValidIn, canStoreIn, isMemoryAccessDestIn, memoryAddressDestIn,
           storeDataIn, opcodeIn, reqackIn, respcycIn,
    input  reqcycOut, reqOut, reqtagOut, respackOut, stallOut, storeDoneOut,
           timeoutErrOut
  );
endinterface

// File: rtl/store_commit.sv
// Commits one store as an address beat then a data beat, then waits for the write response.
// Optional response watchdog is built only when STORE_COMMIT_TIMEOUT_EN is defined.
module store_commit #(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  store_commit_if.master bus
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_RESP, ACK} stateT;

  localparam logic [3:0] MemSpace = 4'h1;

  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("store_commit: TIMEOUT_CYCLES must be at least 1");
  end

  stateT             state;
  logic [ADDR_W-1:0] dataQ;
  logic [ADDR_W-1:0] reqQ;
  logic [12:0]       reqtagQ;
  logic              reqcycQ;
  logic              respackQ;
  logic              doneQ;
  logic              stallQ;
  logic              acceptNow;
  logic              passNow;

`ifdef STORE_COMMIT_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] waitCnt;
  logic            timeoutErrQ;
  logic            timeoutNow;

  assign timeoutNow = (waitCnt == CntW'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    acceptNow = 1'b0;
    passNow   = 1'b0;
    if (state == IDLE && bus.opcodeValidIn && bus.canStoreIn) begin
      acceptNow = bus.isMemoryAccessDestIn;
      passNow   = !bus.isMemoryAccessDestIn;
    end
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dataQ    <= '0;
      reqQ     <= '0;
      reqtagQ  <= '0;
      reqcycQ  <= 1'b0;
      respackQ <= 1'b0;
      doneQ    <= 1'b0;
      stallQ   <= 1'b0;
`ifdef STORE_COMMIT_TIMEOUT_EN
      waitCnt     <= '0;
      timeoutErrQ <= 1'b0;
`endif
    end else begin
      respackQ <= 1'b0;
      doneQ    <= 1'b0;
      case (state)
        IDLE: begin
          if (acceptNow) begin
            state   <= ADDR;
            dataQ   <= bus.storeDataIn;
            reqQ    <= bus.memoryAddressDestIn;
            reqtagQ <= {1'b0, MemSpace, bus.opcodeIn};
            reqcycQ <= 1'b1;
            stallQ  <= 1'b1;
          end
        end
        ADDR: begin
          if (bus.reqackIn) begin
            state <= DATA;
            reqQ  <= dataQ;
          end
        end
        DATA: begin
          if (bus.reqackIn) begin
            state   <= WAIT_RESP;
            reqcycQ <= 1'b0;
            reqQ    <= '0;
            reqtagQ <= '0;
`ifdef STORE_COMMIT_TIMEOUT_EN
            waitCnt <= '0;
`endif
          end
        end
        WAIT_RESP: begin
          // A response on the final watchdog cycle still wins over the timeout.
          if (bus.respcycIn) begin
            state    <= ACK;
            respackQ <= 1'b1;
            doneQ    <= 1'b1;
          end
`ifdef STORE_COMMIT_TIMEOUT_EN
          else if (timeoutNow) begin
            state       <= IDLE;
            stallQ      <= 1'b0;
            timeoutErrQ <= 1'b1;
          end else begin
            waitCnt <= waitCnt + CntW'(1);
          end
`endif
        end
        ACK: begin
          state  <= IDLE;
          stallQ <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // IDLE pass-through and same-cycle acceptance must be visible without a register delay.
  assign bus.reqcycOut    = reqcycQ;
  assign bus.reqOut       = reqQ;
  assign bus.reqtagOut    = reqtagQ;
  assign bus.respackOut   = respackQ;
  assign bus.stallOut     = stallQ | acceptNow;
  assign bus.storeDoneOut = doneQ | passNow;
`ifdef STORE_COMMIT_TIMEOUT_EN
  assign bus.timeoutErrOut = timeoutErrQ;
`else
  assign bus.timeoutErrOut = 1'b0;
`endif

endmodule

// File: tb/tb_store_commit.sv
// Directed bench for store_commit: a transaction-level model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_store_commit;
  localparam int ADDR_W = 64;
`ifdef STORE_COMMIT_TIMEOUT_EN
  localparam int TO_CYC = 8;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TO_CYC = 1024;
  localparam bit TO_EN  = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_commit_if #(.ADDR_W(ADDR_W)) bus ();

  store_commit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int nChecks = 0;
  int nPass   = 0;
  bit cmpEn   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Transaction model: a store is busy until its ack cycle; beats 0/1 are address/data, 2 is response wait.
  bit          mBusy = 1'b0;
  int          mBeat = 0;
  bit          mAckNow = 1'b0;
  int          mWait = 0;
  bit          mTimeoutErr = 1'b0;
  logic [63:0] mAddr = '0;
  logic [63:0] mData = '0;
  logic [7:0]  mOp = '0;

  always @(posedge clk) begin
    if (reset) begin
      mBusy = 1'b0; mBeat = 0; mAckNow = 1'b0; mWait = 0; mTimeoutErr = 1'b0;
      mAddr = '0; mData = '0; mOp = '0;
    end else if (mAckNow) begin
      mAckNow = 1'b0;
      mBusy   = 1'b0;
    end else if (!mBusy) begin
      if (bus.opcodeValidIn && bus.canStoreIn && bus.isMemoryAccessDestIn) begin
        mBusy = 1'b1; mBeat = 0;
        mAddr = bus.memoryAddressDestIn; mData = bus.storeDataIn; mOp = bus.opcodeIn;
      end
    end else if (mBeat < 2) begin
      if (bus.reqackIn) begin
        mBeat = mBeat + 1;
        mWait = 0;
      end
    end else if (bus.respcycIn) begin
      mAckNow = 1'b1;
    end else if (TO_EN) begin
      mWait = mWait + 1;
      if (mWait >= TO_CYC) begin
        mTimeoutErr = 1'b1;
        mBusy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit upOk, accNow, passNow, expCyc;
    if (cmpEn) begin
      upOk    = bus.opcodeValidIn && bus.canStoreIn && !mBusy;
      accNow  = upOk && bus.isMemoryAccessDestIn;
      passNow = upOk && !bus.isMemoryAccessDestIn;
      expCyc  = mBusy && !mAckNow && (mBeat < 2);
      check("m_reqcyc", bus.reqcycOut, expCyc);
      if (expCyc) begin
        check("m_req", bus.reqOut, (mBeat == 0) ? mAddr : mData);
        check("m_reqtag", bus.reqtagOut, {1'b0, 4'h1, mOp});
      end
      check("m_respack", bus.respackOut, mAckNow);
      check("m_stall", bus.stallOut, mBusy || accNow);
      check("m_done", bus.storeDoneOut, mAckNow || passNow);
      check("m_timeout", bus.timeoutErrOut, mTimeoutErr);
    end
  end

  // Inputs change only just after the active edge; literal checks happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] op);
    bus.opcodeValidIn = 1'b1; bus.canStoreIn = 1'b1; bus.isMemoryAccessDestIn = 1'b1;
    bus.memoryAddressDestIn = a; bus.storeDataIn = d; bus.opcodeIn = op;
  endtask

  task automatic noStore();
    bus.opcodeValidIn = 1'b0; bus.canStoreIn = 1'b0; bus.isMemoryAccessDestIn = 1'b0;
  endtask

  initial begin
    noStore();
    bus.memoryAddressDestIn = '0; bus.storeDataIn = '0; bus.opcodeIn = '0;
    bus.reqackIn = 1'b0; bus.respcycIn = 1'b0;
    reset = 1'b1;
    tick(); tick();
    mid();
    check("rst_reqcyc", bus.reqcycOut, 0);
    check("rst_req", bus.reqOut, 0);
    check("rst_reqtag", bus.reqtagOut, 0);
    check("rst_respack", bus.respackOut, 0);
    check("rst_stall", bus.stallOut, 0);
    check("rst_done", bus.storeDoneOut, 0);
    check("rst_timeout", bus.timeoutErrOut, 0);
    tick(); reset = 1'b0; cmpEn = 1'b1;

    // Basic store, acks and response held high throughout (early/late ones must be ignored).
    tick(); store(64'h1000, 64'hDEAD_BEEF, 8'h89); bus.reqackIn = 1'b1; bus.respcycIn = 1'b1;
    mid(); check("b_acc_stall", bus.stallOut, 1); check("b_acc_done", bus.storeDoneOut, 0);
    tick(); noStore();
    mid(); check("b_addr_cyc", bus.reqcycOut, 1); check("b_addr", bus.reqOut, 64'h1000);
    check("b_tag", bus.reqtagOut, 13'h0189);
    tick(); mid(); check("b_data", bus.reqOut, 64'hDEAD_BEEF); check("b_data_tag", bus.reqtagOut, 13'h0189);
    tick(); mid(); check("b_wait_cyc", bus.reqcycOut, 0); check("b_wait_done", bus.storeDoneOut, 0);
    tick(); mid(); check("b_done4", bus.storeDoneOut, 1); check("b_respack", bus.respackOut, 1);
    tick(); mid(); check("b_idle_done", bus.storeDoneOut, 0); check("b_idle_stall", bus.stallOut, 0);
    bus.reqackIn = 1'b0; bus.respcycIn = 1'b0;

    // Address beat held off for three cycles; non-store offered while busy is ignored.
    tick(); store(64'h1000, 64'h0123_4567_89AB_CDEF, 8'h12);
    tick(); noStore();
    for (int i = 0; i < 3; i++) begin
      mid(); check("h_req", bus.reqOut, 64'h1000); check("h_cyc", bus.reqcycOut, 1);
      check("h_stall", bus.stallOut, 1);
      tick();
    end
    bus.reqackIn = 1'b1;
    tick(); bus.reqackIn = 1'b0;
    mid(); check("h_data_hold", bus.reqOut, 64'h0123_4567_89AB_CDEF);
    tick(); bus.reqackIn = 1'b1;
    tick(); bus.reqackIn = 1'b0;
    bus.opcodeValidIn = 1'b1; bus.canStoreIn = 1'b1; bus.isMemoryAccessDestIn = 1'b0;
    mid(); check("h_busy_pass", bus.storeDoneOut, 0); check("h_busy_stall", bus.stallOut, 1);
    tick(); noStore();
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    bus.respcycIn = 1'b1;
    tick(); bus.respcycIn = 1'b0;
    mid(); check("h_done", bus.storeDoneOut, 1);

    // Zero-latency non-store pass-through, then refused handshakes.
    tick(); bus.opcodeValidIn = 1'b1; bus.canStoreIn = 1'b1; bus.isMemoryAccessDestIn = 1'b0;
    mid(); check("p_done", bus.storeDoneOut, 1); check("p_cyc", bus.reqcycOut, 0);
    check("p_stall", bus.stallOut, 0);
    tick(); noStore();
    mid(); check("p_after", bus.storeDoneOut, 0);
    tick(); bus.opcodeValidIn = 1'b1; bus.canStoreIn = 1'b0; bus.isMemoryAccessDestIn = 1'b1;
    mid(); check("r_nocan_stall", bus.stallOut, 0); check("r_nocan_done", bus.storeDoneOut, 0);
    tick(); bus.opcodeValidIn = 1'b0; bus.canStoreIn = 1'b1;
    mid(); check("r_noval_stall", bus.stallOut, 0);
    tick(); noStore();
    mid(); check("r_no_cyc", bus.reqcycOut, 0);

    // Back-to-back: offer held through ACK is taken only on the following IDLE cycle.
    tick(); store(64'h3000, 64'hAAAA, 8'h7F); bus.reqackIn = 1'b1; bus.respcycIn = 1'b1;
    tick(); noStore();
    tick();
    tick(); store(64'h2000, 64'hBBBB, 8'h05);
    tick(); mid(); check("bb_ack_done", bus.storeDoneOut, 1);
    tick(); mid(); check("bb_accept", bus.stallOut, 1); check("bb_idle_done", bus.storeDoneOut, 0);
    tick(); noStore();
    mid(); check("bb_addr", bus.reqOut, 64'h2000); check("bb_tag", bus.reqtagOut, 13'h0105);
    tick(); tick(); tick(); mid(); check("bb_done", bus.storeDoneOut, 1);
    tick(); bus.reqackIn = 1'b0; bus.respcycIn = 1'b0;

    // Reset in the DATA state abandons the store; a later stray response is ignored.
    tick(); store(64'h4000, 64'hCCCC, 8'h33); bus.reqackIn = 1'b1;
    tick(); noStore();
    tick(); bus.reqackIn = 1'b0;
    mid(); check("x_data", bus.reqOut, 64'hCCCC);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; bus.respcycIn = 1'b1;
    mid(); check("x_cyc", bus.reqcycOut, 0); check("x_stall", bus.stallOut, 0);
    check("x_respack", bus.respackOut, 0);
    tick(); mid(); check("x_respack2", bus.respackOut, 0); check("x_done2", bus.storeDoneOut, 0);
    tick(); bus.respcycIn = 1'b0;

    // Response never arrives.
    tick(); store(64'h5000, 64'hDDDD, 8'h44); bus.reqackIn = 1'b1;
    tick(); noStore();
    tick();
    tick(); bus.reqackIn = 1'b0;
`ifdef STORE_COMMIT_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      mid(); check("t_wait_err", bus.timeoutErrOut, 0); check("t_wait_stall", bus.stallOut, 1);
      tick();
    end
    mid(); check("t_err", bus.timeoutErrOut, 1); check("t_idle_stall", bus.stallOut, 0);
    check("t_no_done", bus.storeDoneOut, 0); check("t_no_respack", bus.respackOut, 0);
    tick(); bus.respcycIn = 1'b1;
    mid(); check("t_stray", bus.respackOut, 0); check("t_sticky", bus.timeoutErrOut, 1);
    tick(); bus.respcycIn = 1'b0;
    tick(); tick(); mid(); check("t_sticky2", bus.timeoutErrOut, 1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    mid(); check("t_cleared", bus.timeoutErrOut, 0);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
    end
    mid(); check("w_stall", bus.stallOut, 1); check("w_err", bus.timeoutErrOut, 0);
    tick(); bus.respcycIn = 1'b1;
    tick(); bus.respcycIn = 1'b0;
    mid(); check("w_done", bus.storeDoneOut, 1);
`endif
    tick(); tick();
    mid();
    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout want completion");
    $fatal(1, "tb_store_commit watchdog expired");
  end
endmodule
